// File: rtl/fios_io_pkg.sv
// Shared types and constants for the FIOS operand server / result collector.
// Holds the word width, FSM state encoding and load buffer selectors.
package fios_io_pkg;

    localparam int WORD_W = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } fios_io_state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_P = 2'd2;

endpackage

// File: rtl/fios_word_buf.sv
// S x 17 register file: one write port, one registered read port.
// Storage is not reset; only the read register is.
module fios_word_buf
    import fios_io_pkg::*;
#(
    parameter int S  = 8,
    parameter int AW = $clog2(S)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [S];

    // Word storage write
    always_ff @(posedge clock_i) begin
        if (wr_en && int'(wr_addr) < S)
            mem[wr_addr] <= wr_data;
    end

    // Registered read; out-of-range addresses read as zero
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i)
            rd_data <= '0;
        else
            rd_data <= (int'(rd_addr) < S) ? mem[rd_addr] : '0;
    end

endmodule

// File: rtl/fios_io_ctrl.sv
// Operand server and result collector for the cascaded FIOS multiplier.
// Optional FIOS_IO_ERR_FLAGS_EN adds sticky err_o[2:0] diagnostics.
module fios_io_ctrl
    import fios_io_pkg::*;
#(
    parameter int s     = 8,
    parameter int PE_NB = s
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    load_we_i,
    input  logic [1:0]              load_sel_i,
    input  logic [$clog2(s)-1:0]    load_addr_i,
    input  logic [WORD_W-1:0]       load_data_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    res_valid_o,
    input  logic [$clog2(s)-1:0]    res_rd_addr_i,
    output logic [WORD_W-1:0]       res_data_o,
    output logic                    start_o,
    output logic [PE_NB*WORD_W-1:0] a_o,
    input  logic                    a_shift_i,
    input  logic                    b_fetch_i,
    input  logic                    p_fetch_i,
    output logic [WORD_W-1:0]       b_o,
    output logic [WORD_W-1:0]       p_o,
    input  logic                    RES_push_i,
    input  logic [WORD_W-1:0]       RES_i,
`ifdef FIOS_IO_ERR_FLAGS_EN
    output logic [2:0]              err_o,
`endif
    input  logic                    done_i
);

    localparam int AW   = $clog2(s);
    localparam int CW   = $clog2(s + 1) + 1;
    localparam int NWIN = (s + PE_NB - 1) / PE_NB;

    fios_io_state_t state;

    logic [WORD_W-1:0]       a_mem [s];
    logic [CW-1:0]           a_cnt, a_cnt_nxt;
    logic [AW-1:0]           b_ptr, b_ptr_nxt;
    logic [AW-1:0]           p_ptr, p_ptr_nxt;
    logic [AW:0]             res_ptr, res_ptr_nxt;
    logic [PE_NB*WORD_W-1:0] a_win;
    logic                    run, load_ok, push_ok;

    assign run     = (state == RUN);
    assign load_ok = load_we_i && (state == IDLE || state == DONE)
                     && int'(load_addr_i) < s;
    assign push_ok = run && RES_push_i && int'(res_ptr) < s;

    // Control FSM with registered handshake outputs
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            start_o     <= 1'b0;
            busy_o      <= 1'b0;
            res_valid_o <= 1'b0;
        end else begin
            start_o <= 1'b0;
            unique case (state)
                IDLE: if (start_i) begin
                    state   <= START;
                    start_o <= 1'b1;
                    busy_o  <= 1'b1;
                end
                START: state <= RUN;
                RUN: if (done_i) begin
                    state       <= DONE;
                    busy_o      <= 1'b0;
                    res_valid_o <= 1'b1;
                end
                DONE: if (start_i) begin
                    state       <= START;
                    start_o     <= 1'b1;
                    busy_o      <= 1'b1;
                    res_valid_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Next pointer values; cleared in START, stepped only in RUN
    always_comb begin
        a_cnt_nxt   = a_cnt;
        b_ptr_nxt   = b_ptr;
        p_ptr_nxt   = p_ptr;
        res_ptr_nxt = res_ptr;
        if (state == START) begin
            a_cnt_nxt   = '0;
            b_ptr_nxt   = '0;
            p_ptr_nxt   = '0;
            res_ptr_nxt = '0;
        end else if (run) begin
            if (a_shift_i && int'(a_cnt) < NWIN)
                a_cnt_nxt = a_cnt + CW'(1);
            if (b_fetch_i)
                b_ptr_nxt = (int'(b_ptr) == s - 1) ? '0 : b_ptr + AW'(1);
            if (p_fetch_i)
                p_ptr_nxt = (int'(p_ptr) == s - 1) ? '0 : p_ptr + AW'(1);
            if (push_ok)
                res_ptr_nxt = res_ptr + (AW+1)'(1);
        end
    end

    // Pointer registers
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            a_cnt   <= '0;
            b_ptr   <= '0;
            p_ptr   <= '0;
            res_ptr <= '0;
        end else begin
            a_cnt   <= a_cnt_nxt;
            b_ptr   <= b_ptr_nxt;
            p_ptr   <= p_ptr_nxt;
            res_ptr <= res_ptr_nxt;
        end
    end

    // a operand storage, written by host loads only
    always_ff @(posedge clock_i) begin
        if (load_ok && load_sel_i == SEL_A)
            a_mem[load_addr_i] <= load_data_i;
    end

    // Window of PE_NB a words at the upcoming counter; past the end reads 0
    always_comb begin
        a_win = '0;
        for (int k = 0; k < PE_NB; k++) begin
            if (int'(a_cnt_nxt) * PE_NB + k < s)
                a_win[k*WORD_W +: WORD_W] =
                    a_mem[AW'(int'(a_cnt_nxt) * PE_NB + k)];
        end
    end

    // Registered a window
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i)
            a_o <= '0;
        else
            a_o <= a_win;
    end

    fios_word_buf #(.S(s), .AW(AW)) u_b_buf (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wr_en   (load_ok && load_sel_i == SEL_B),
        .wr_addr (load_addr_i),
        .wr_data (load_data_i),
        .rd_addr (b_ptr_nxt),
        .rd_data (b_o)
    );

    fios_word_buf #(.S(s), .AW(AW)) u_p_buf (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wr_en   (load_ok && load_sel_i == SEL_P),
        .wr_addr (load_addr_i),
        .wr_data (load_data_i),
        .rd_addr (p_ptr_nxt),
        .rd_data (p_o)
    );

    fios_word_buf #(.S(s), .AW(AW)) u_res_buf (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wr_en   (push_ok),
        .wr_addr (res_ptr[AW-1:0]),
        .wr_data (RES_i),
        .rd_addr (res_rd_addr_i),
        .rd_data (res_data_o)
    );

`ifdef FIOS_IO_ERR_FLAGS_EN
    logic [2:0] err_set;

    assign err_set[0] = load_we_i && (state == START || run);
    assign err_set[1] = run && RES_push_i && int'(res_ptr) >= s;
    assign err_set[2] = !run && (a_shift_i || b_fetch_i || p_fetch_i
                                 || RES_push_i || done_i);

    // Sticky error flags, cleared at each new start
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i)
            err_o <= '0;
        else if (state == START)
            err_o <= '0;
        else
            err_o <= err_o | err_set;
    end
`endif

endmodule

// File: tb/tb_fios_io_ctrl.sv
// Directed bench for fios_io_ctrl with s=4, PE_NB=2.
// Honours FIOS_IO_ERR_FLAGS_EN when the design is built with it.
module tb_fios_io_ctrl;

    localparam int S  = 4;
    localparam int PE = 2;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        load_we_i;
    logic [1:0]  load_sel_i;
    logic [1:0]  load_addr_i;
    logic [16:0] load_data_i;
    logic        start_i;
    logic        busy_o;
    logic        res_valid_o;
    logic [1:0]  res_rd_addr_i;
    logic [16:0] res_data_o;
    logic        start_o;
    logic [33:0] a_o;
    logic        a_shift_i;
    logic        b_fetch_i;
    logic        p_fetch_i;
    logic [16:0] b_o;
    logic [16:0] p_o;
    logic        RES_push_i;
    logic [16:0] RES_i;
    logic        done_i;
`ifdef FIOS_IO_ERR_FLAGS_EN
    logic [2:0]  err_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    fios_io_ctrl #(.s(S), .PE_NB(PE)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .load_we_i     (load_we_i),
        .load_sel_i    (load_sel_i),
        .load_addr_i   (load_addr_i),
        .load_data_i   (load_data_i),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .res_valid_o   (res_valid_o),
        .res_rd_addr_i (res_rd_addr_i),
        .res_data_o    (res_data_o),
        .start_o       (start_o),
        .a_o           (a_o),
        .a_shift_i     (a_shift_i),
        .b_fetch_i     (b_fetch_i),
        .p_fetch_i     (p_fetch_i),
        .b_o           (b_o),
        .p_o           (p_o),
        .RES_push_i    (RES_push_i),
        .RES_i         (RES_i),
`ifdef FIOS_IO_ERR_FLAGS_EN
        .err_o         (err_o),
`endif
        .done_i        (done_i)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] sel, input logic [1:0] addr,
                        input logic [16:0] data);
        load_we_i   = 1'b1;
        load_sel_i  = sel;
        load_addr_i = addr;
        load_data_i = data;
        tick();
        load_we_i   = 1'b0;
    endtask

    task automatic push(input logic [16:0] w, input logic dn);
        RES_push_i = 1'b1;
        RES_i      = w;
        done_i     = dn;
        tick();
        RES_push_i = 1'b0;
        done_i     = 1'b0;
    endtask

    task automatic read_res(input logic [1:0] addr, input logic [16:0] exp,
                            input string tag);
        res_rd_addr_i = addr;
        tick();
        check(tag, 64'(res_data_o), 64'(exp));
    endtask

    initial begin
        reset_i       = 1'b0;
        load_we_i     = 1'b0;
        load_sel_i    = 2'd0;
        load_addr_i   = 2'd0;
        load_data_i   = 17'd0;
        start_i       = 1'b0;
        res_rd_addr_i = 2'd0;
        a_shift_i     = 1'b0;
        b_fetch_i     = 1'b0;
        p_fetch_i     = 1'b0;
        RES_push_i    = 1'b0;
        RES_i         = 17'd0;
        done_i        = 1'b0;

        tick();
        tick();
        check("rst_start", 64'(start_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(res_valid_o), 64'd0);
        check("rst_b", 64'(b_o), 64'd0);
        check("rst_p", 64'(p_o), 64'd0);
        check("rst_a", 64'(a_o), 64'd0);
        check("rst_res", 64'(res_data_o), 64'd0);
        reset_i = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            load(2'd0, 2'(i), 17'(i + 1));
            load(2'd1, 2'(i), 17'(i + 5));
            load(2'd2, 2'(i), 17'(i + 9));
        end
        load(2'd3, 2'd0, 17'h1_0000);

        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("start_pulse", 64'(start_o), 64'd1);
        check("start_busy", 64'(busy_o), 64'd1);
        tick();
        check("start_drop", 64'(start_o), 64'd0);
        check("run_a0", 64'(a_o), {30'd0, 17'd2, 17'd1});
        check("run_b0", 64'(b_o), 64'd5);
        check("run_p0", 64'(p_o), 64'd9);

        a_shift_i = 1'b1;
        tick();
        check("a_shift1", 64'(a_o), {30'd0, 17'd4, 17'd3});
        tick();
        check("a_shift2", 64'(a_o), 64'd0);
        tick();
        a_shift_i = 1'b0;
        check("a_sat", 64'(a_o), 64'd0);

        b_fetch_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("b_fetch%0d", i), 64'(b_o),
                  64'(5 + ((i + 1) % 4)));
            check($sformatf("p_hold%0d", i), 64'(p_o), 64'd9);
        end
        p_fetch_i = 1'b1;
        tick();
        b_fetch_i = 1'b0;
        p_fetch_i = 1'b0;
        check("both_b", 64'(b_o), 64'd7);
        check("both_p", 64'(p_o), 64'd10);

        load(2'd1, 2'd0, 17'h1);
        check("busy_load", 64'(busy_o), 64'd1);

        push(17'h1FFFF, 1'b0);
        push(17'h00001, 1'b0);
        push(17'h0ABCD, 1'b0);
        check("pre_done", 64'(res_valid_o), 64'd0);
        push(17'h12345, 1'b1);
        check("done_valid", 64'(res_valid_o), 64'd1);
        check("done_busy", 64'(busy_o), 64'd0);
        read_res(2'd0, 17'h1FFFF, "res0");
        read_res(2'd1, 17'h00001, "res1");
        read_res(2'd2, 17'h0ABCD, "res2");
        read_res(2'd3, 17'h12345, "res3");

        b_fetch_i = 1'b1;
        tick();
        b_fetch_i = 1'b0;
        check("done_fetch_ign", 64'(b_o), 64'd7);

        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("restart_pulse", 64'(start_o), 64'd1);
        check("restart_valid", 64'(res_valid_o), 64'd0);
        tick();
        check("b0_kept", 64'(b_o), 64'd5);
        check("a_reset_win", 64'(a_o), {30'd0, 17'd2, 17'd1});

        for (int i = 0; i < 5; i++)
            push(17'(17'h11 * (i + 1)), 1'b0);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check("ovf_valid", 64'(res_valid_o), 64'd1);
        for (int i = 0; i < 4; i++)
            read_res(2'(i), 17'(17'h11 * (i + 1)), $sformatf("ovf_res%0d", i));
`ifdef FIOS_IO_ERR_FLAGS_EN
        check("err_ovf", 64'(err_o[1]), 64'd1);
`endif

        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("mid_busy", 64'(busy_o), 64'd1);
        reset_i = 1'b0;
        #1;
        check("async_busy", 64'(busy_o), 64'd0);
        check("async_start", 64'(start_o), 64'd0);
        check("async_valid", 64'(res_valid_o), 64'd0);
        tick();
        reset_i = 1'b1;
        tick();
        check("idle_busy", 64'(busy_o), 64'd0);

        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("post_rst_start", 64'(start_o), 64'd1);
        tick();
        check("post_rst_a", 64'(a_o), {30'd0, 17'd2, 17'd1});
        check("post_rst_b", 64'(b_o), 64'd5);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fios_io_ctrl.md
# fios_io_ctrl

Operand server and result collector on the far side of the cascaded FIOS Montgomery multiplier's word interface. Buffers host-loaded a, b and p operands and answers the multiplier's `a_shift`, `b_fetch` and `p_fetch` requests with the correct 17-bit words. Captures the `RES_push` word stream into a result buffer and hands it back to the host once `done` is seen. Sits between the host/bus adapter and the multiplier top level.

## Interface
Parameters:
- `s`, 8, number of 17-bit words per operand.
- `PE_NB`, `s`, number of PEs; sets the width of `a_o`.

Ports:
- `clock_i` in 1: single clock.
- `reset_i` in 1: asynchronous, active-low reset.
- `load_we_i` in 1: host operand write strobe.
- `load_sel_i` in 2: target buffer; 0 = a, 1 = b, 2 = p, 3 = ignored.
- `load_addr_i` in $clog2(s): word index.
- `load_data_i` in 17: word to write.
- `start_i` in 1: host start pulse.
- `busy_o` out 1: high in START and RUN.
- `res_valid_o` out 1: high in DONE.
- `res_rd_addr_i` in $clog2(s): result read index.
- `res_data_o` out 17: result word, registered.
- `start_o` out 1: one-cycle start pulse to the multiplier.
- `a_o` out PE_NB*17: current a window; word 0 is in the LSBs.
- `a_shift_i` in 1: advance the a window.
- `b_fetch_i` in 1: advance the b pointer.
- `p_fetch_i` in 1: advance the p pointer.
- `b_o` out 17: current b word.
- `p_o` out 17: current p word.
- `RES_push_i` in 1: result word strobe.
- `RES_i` in 17: result word.
- `done_i` in 1: multiplication complete.

## Operation
- FSM states are IDLE, START, RUN and DONE. Reset enters IDLE.
- IDLE → START on `start_i`.
- START lasts one cycle. It asserts `start_o` and clears `a_cnt`, `b_ptr`, `p_ptr` and `res_ptr`. START → RUN.
- RUN → DONE on `done_i`.
- DONE → START on `start_i`. DONE is held otherwise, and the results remain readable.
- Loads:
  - Accepted only in IDLE and DONE. A load in START or RUN is dropped and leaves the buffers unchanged.
  - A load with `load_addr_i` ≥ s is dropped.
- a window: `a_o` word k = a[a_cnt*PE_NB + k], or 0 when the index is ≥ s. In RUN, `a_shift_i` increments `a_cnt`. It saturates once the window is entirely past s-1.
- b/p:
  - `b_o` = b[b_ptr] and `p_o` = p[p_ptr].
  - In RUN, each fetch increments its pointer modulo s, wrapping s-1 → 0.
  - The b and p pointers are independent, and simultaneous fetches are both served.
- Results:
  - In RUN, `RES_push_i` writes `RES_i` to res[res_ptr] and increments `res_ptr`.
  - Pushes beyond s words are dropped.
  - When `RES_push_i` and `done_i` arrive in the same cycle, the word is stored first, then the FSM enters DONE.
- Strobes outside RUN (`a_shift_i`, fetches, pushes, `done_i`) are ignored.
- A `start_i` in START or RUN is ignored.
- Reset values:
  - Outputs `start_o`, `busy_o`, `res_valid_o`, `b_o`, `p_o`, `res_data_o` and `a_o` are all 0.
  - Pointers are 0.
  - Buffer contents are not reset.

## Timing
- `start_o` is asserted the cycle after `start_i` is sampled. `busy_o` rises in the same cycle as `start_o`.
- `b_o`, `p_o` and `a_o` are registered:
  - A strobe sampled at cycle t shows the new word at t+1.
  - The first words (index 0) are valid in the first RUN cycle.
  - Back-to-back fetches every cycle are supported.
- `res_data_o` is valid 1 cycle after `res_rd_addr_i`.
- `res_valid_o` rises the cycle after `done_i` is sampled.
- Reset asserted mid-RUN returns to IDLE asynchronously, with no `start_o` and no `res_valid_o`.

## Configuration
- `FIOS_IO_ERR_FLAGS_EN` compiled in adds output `err_o[2:0]`, sticky and cleared in START:
  - bit 0: load dropped because the FSM was busy.
  - bit 1: push overflow.
  - bit 2: strobe received outside RUN.
- Without the macro, the port and the error logic are absent. Dropping behaviour is identical in both builds.

## Structure
- Package `fios_io_pkg` holds:
  - the `WORD_W = 17` constant;
  - the `fios_io_state_t` enum (IDLE/START/RUN/DONE);
  - the `load_sel` encodings (SEL_A/SEL_B/SEL_P).
- Sub-module `fios_word_buf` is an s×17 register file with one write port and one registered read port. It is instantiated for b, p and res.
- The a buffer is a flat register array because it needs a wide window read.

## Test plan
- s=4, PE_NB=2:
  - Stimulus: load a={1,2,3,4}, b={5,6,7,8}, then `start_i`.
  - Response: `start_o` is pulsed for one cycle, and `a_o` = {2,1}.
  - Stimulus: one `a_shift_i`.
  - Response: `a_o` = {4,3}.
  - Stimulus: a second `a_shift_i`.
  - Response: `a_o` = {0,0}.
- Stimulus: 5 `b_fetch_i` pulses on consecutive cycles.
  - Response: `b_o` sequence is 5,6,7,8,5,6; the wrap is verified, and `p_o` is unchanged.
- Stimulus: push RES 0x1FFFF, 0x00001, 0x0ABCD, 0x12345 with `done_i` in the same cycle as the last push.
  - Response: `res_valid_o` rises the next cycle, and read addresses 0..3 return those words.
- Stimulus: 5 pushes, then `done_i`.
  - Response: res[0..3] hold the first 4 words, and the 5th word is dropped; `err_o[1]` = 1 when the macro is compiled in.
- Stimulus: `load_we_i` to b[0]=0x1 during RUN.
  - Response: b[0] is unchanged after DONE.
- Stimulus: `reset_i` low mid-RUN.
  - Response: `busy_o` = 0 immediately, and the state is IDLE; a new start sequence then works.
